// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared types, defaults and port-slicing helper for regfile_mp
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_e;

  // Low bit of port `port` inside a packed bus of `width`-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ============================================================================
// regfile_mp_if : decode/writeback-facing bus of the multi-port register file
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     clear_req;
  logic                     busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, clear_req,
    input  rd_data, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, clear_req,
    output rd_data, busy
  );

endinterface

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
// regfile_rd_port : one read port with clear gating, zero-reg, bypass, opt. reg
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit RD_REG   = 1'b0
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              idle_i,
  input  wire logic [ADDR_W-1:0] rd_addr_i,
  input  wire logic [DATA_W-1:0] arr_data_i,
  input  wire logic              wr_commit_i,
  input  wire logic [ADDR_W-1:0] wr_addr_i,
  input  wire logic [DATA_W-1:0] wr_data_i,
  output logic      [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  // Zero-register gating outranks bypass; wr_commit_i already excludes
  // dropped writes to entry 0.
  always_comb begin
    rd_d = arr_data_i;
    if (!idle_i) begin
      rd_d = '0;
    end else if (ZERO_REG && (rd_addr_i == '0)) begin
      rd_d = '0;
    end else if (BYPASS && wr_commit_i && (wr_addr_i == rd_addr_i)) begin
      rd_d = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data_o = RD_REG ? rd_q : rd_d;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : parametrised N-read/1-write register file with hardware clear
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit RD_REG   = 1'b0
) (
  input wire logic    clk,
  input wire logic    rst,
  regfile_mp_if.slave rf
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = {1'b0, {ADDR_W{1'b1}}};

  rf_state_e         state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic idle;
  logic zero_drop;
  logic wr_commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      RF_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          state_d   = RF_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      RF_IDLE: begin
        if (rf.clear_req) begin
          state_d   = RF_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = RF_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign idle      = (state_q == RF_IDLE);
  assign rf.busy   = ~idle;
  assign zero_drop = ZERO_REG && (rf.wr_addr == '0);
  assign wr_commit = idle && !rst && rf.wr_en && !zero_drop;

  // The clear walk owns the write port while busy; user writes are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!idle) begin
        mem_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
      end else if (wr_commit) begin
        mem_q[rf.wr_addr] <= rf.wr_data;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] arr_val;
    logic [DATA_W-1:0] dout;

    assign addr    = rf.rd_addr[slice_lo(gi, ADDR_W) +: ADDR_W];
    assign arr_val = mem_q[addr];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .RD_REG   (RD_REG)
    ) u_rd_port (
      .clk         (clk),
      .rst         (rst),
      .idle_i      (idle),
      .rd_addr_i   (addr),
      .arr_data_i  (arr_val),
      .wr_commit_i (wr_commit),
      .wr_addr_i   (rf.wr_addr),
      .wr_data_i   (rf.wr_data),
      .rd_data_o   (dout)
    );

    assign rf.rd_data[slice_lo(gi, DATA_W) +: DATA_W] = dout;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the MIPS datapath. Next generation of the 2-read/1-write integer register file.
- Adds configurable width, depth and read-port count, and optional hardwired zero register.
- Adds write-to-read bypass, optional registered read, and a sequential hardware clear FSM so all entries start at a known value after reset or on request.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, bits per register
ADDR_W, 5, address bits; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port
RD_REG, 0, 0 = combinational read; 1 = read data registered (1-cycle latency)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
clear_req  in  1  request full-array clear (sampled in IDLE only)
busy  out  1  high while clear in progress; reads/writes not serviced

Behaviour:
- FSM states are CLEAR and IDLE.
- Reset (rst=1 at a posedge):
  - Next state is CLEAR with clr_cnt=0 and busy=1.
  - Registered rd_data (RD_REG=1) resets to 0.
  - rst asserted mid-clear restarts clr_cnt at 0.
- CLEAR:
  - Each cycle writes 0 to entry clr_cnt, then clr_cnt increments.
  - After entry DEPTH-1 is written, go to IDLE; busy falls on that edge.
  - Clear therefore takes exactly DEPTH cycles after reset deassertion; busy is high for DEPTH cycles.
  - In CLEAR, wr_en is ignored, clear_req is ignored, and all rd_data read 0.
- IDLE:
  - wr_en=1 writes wr_data to wr_addr at the posedge.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
  - clear_req=1 moves the FSM to CLEAR with clr_cnt=0 on the next edge.
  - A wr_en in that same cycle still commits, and is later wiped by the clear.
- Read, RD_REG=0:
  - rd_data[i] = array[rd_addr[i]] combinationally.
  - If BYPASS=1, wr_en=1 and wr_addr==rd_addr[i] in IDLE, rd_data[i]=wr_data in the same cycle.
  - With BYPASS=0, the old value is returned until the edge.
- Read, RD_REG=1:
  - rd_data[i] is registered at the posedge from rd_addr[i] sampled at that edge.
  - If BYPASS=1 and a write to the same address commits at that edge, the register captures wr_data.
  - With BYPASS=0 it captures the pre-write value.
  - Latency is 1 cycle.
- Zero register:
  - With ZERO_REG=1, a read of address 0 returns 0 regardless of bypass.
  - With ZERO_REG=0, entry 0 is ordinary storage.
- Read ports are fully independent; any number may address the same entry.
- No read-only or X outputs: after the first clear, every entry holds a defined value.
- clr_cnt is ADDR_W+1 bits wide so the terminal count DEPTH-1 is detected without wrap ambiguity.

Decomposition:
- Shared package regfile_pkg holds:
  - state enum {RF_CLEAR, RF_IDLE}
  - helper function for packed-port slicing
  - default constants for DATA_W and ADDR_W
- One natural sub-module, regfile_rd_port: single read port containing the address compare, bypass mux, zero-reg gating and optional output register.
  - Instantiated NUM_RD times in a generate loop.
- Storage array and clear FSM stay in the top module.

Test Plan:
- Reset, then check the clear sequence.
  - Stimulus: assert rst 3 cycles, release.
  - Required: busy=1 for exactly 32 cycles. Reads of addresses 1, 17 and 31 afterwards return 0x00000000.
- Write, then read back on two ports.
  - Stimulus: after busy=0, write 0xDEADBEEF to r5; next cycle set rd_addr0=5, rd_addr1=5.
  - Required: both ports return 0xDEADBEEF.
  - Required: with RD_REG=1, the value appears one cycle after the address is applied.
- Zero register.
  - Stimulus: write 0x12345678 to r0, then read r0 on both ports.
  - Required: 0x00000000 (ZERO_REG=1); 0x12345678 (ZERO_REG=0 build).
- Bypass.
  - Stimulus: r7 holds 0x1; in one cycle write 0xA5A5A5A5 to r7 and read r7.
  - Required: BYPASS=1 returns 0xA5A5A5A5 in the same cycle (RD_REG=0). BYPASS=0 returns 0x1.
- clear_req with concurrent write.
  - Stimulus: in IDLE, assert clear_req and a write of 0xFF to r3 in the same cycle.
  - Required: busy high for the next 32 cycles; writes issued during busy are dropped; r3 reads 0 afterwards.
- Reset mid-clear.
  - Stimulus: assert rst at clear cycle 10 for 1 cycle.
  - Required: clear restarts, and busy stays high for a full 32 cycles after rst deasserts.
